pipe_stage_chain: RTL and testbench
===================================

# pipe_stage_chain

Parametrised multi-stage pipeline register chain for the P6-family CPU, replacing the per-boundary hand-written stage registers (E→M, M→W, and so on) with one configurable block. It carries an opaque payload plus the hazard-relevant fields (valid, GRF write enable, write address, Tnew) through DEPTH back-to-back registers. Each advance saturating-decrements Tnew, and the block supports global hold, bubble injection and full flush. Per-stage taps feed the hazard/forwarding unit directly.

## Interface
- DATA_W, 96: payload width (ALU result, RD2, PC, PC8, control bits packed by the instantiating stage)
- DEPTH, 2: number of register stages, 1..8
- TNEW_W, 2: Tnew field width
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low (0 clears all state on the next rising clk edge)
- hold  in  1  freeze entire chain
- bubble  in  1  stage 0 captures a bubble; stages 1..DEPTH-1 advance normally
- flush  in  1  clear every stage
- in_valid  in  1  incoming instruction valid
- in_we  in  1  incoming GRF write enable
- in_wa  in  5  incoming GRF write address
- in_tnew  in  TNEW_W  incoming Tnew
- in_data  in  DATA_W  incoming payload
- out_valid, out_we, out_wa, out_tnew, out_data  out  (same widths)  contents of stage DEPTH-1
- tap_valid  out  DEPTH  bit k = stage k valid
- tap_we  out  DEPTH  bit k = stage k write enable
- tap_wa  out  5*DEPTH  stage k at [5k+4:5k]
- tap_tnew  out  TNEW_W*DEPTH  stage k at [TNEW_W*k +: TNEW_W]

## Operation
- Stage record: {valid, we, wa, tnew, data}. A bubble record is all-zero.
- Priority per edge: reset low > flush > hold > bubble > normal advance.
- Reset low or flush: every stage becomes a bubble.
- Hold: every stage keeps its record. Tnew is not decremented.
- Normal advance: stage 0 ← {in_valid, in_we, in_wa, dec(in_tnew), in_data}; stage k ← stage k-1 with tnew replaced by dec(stage k-1 tnew).
- Bubble: stage 0 ← bubble record; stages k≥1 advance as normal. This is the load-use stall pattern: the upstream stage holds, and this chain receives a nop.
- dec(x) = (x == 0) ? 0 : x-1. Saturating, never wraps.
- in_valid = 0 is captured as given. we is not auto-cleared by valid, except as described under Configuration.
- All outputs are direct register outputs. There is no combinational path from any input to any output.
- DEPTH = 1: stage 0 is also the output stage. Taps equal the outputs.

## Timing
- Latency: an instruction presented at edge n appears on out_* after edge n+DEPTH-1 (visible during cycle n+DEPTH-1→n+DEPTH), assuming no hold.
- Each hold cycle adds exactly one cycle of latency.
- Bubble and hold asserted together: hold wins. Nothing moves, and no bubble is inserted.
- Flush and hold together: flush wins, and the chain is cleared.
- Reset low mid-stream: all outputs are 0 after the next edge, regardless of hold, bubble or flush.
- Reset values: out_valid=0, out_we=0, out_wa=0, out_tnew=0, out_data=0. All taps are 0.
- Tnew reaching 0 stays 0 on further advances.

## Configuration
- PIPE_STAGE_ZERO_SUPPRESS_EN
  - Defined: on capture into stage 0, we is forced to 0 when in_wa == 0 or in_valid == 0. The downstream forwarding unit never sees a write to $0.
  - Undefined: in_we is captured verbatim, and $0 filtering is the hazard unit's job.
  - Hold, bubble, flush and Tnew behaviour are identical in both builds.

## Test plan
- Reset, DEPTH=2: drive reset=0 with in_valid=1, in_data=0xAAAA for 2 cycles -> every output and tap is 0. Release reset -> after 2 edges, out_data=0xAAAA.
- Tnew countdown, DEPTH=3, TNEW_W=2: inject in_tnew=2 -> tap_tnew stage0=1, stage1=0, stage2=0. Inject in_tnew=0 -> stays 0 in every stage.
- Hold: with stage0 wa=5 tnew=1 and stage1 wa=7, assert hold for 3 cycles while changing inputs -> taps unchanged and tnew not decremented. Deassert -> normal advance resumes.
- Bubble vs hold: assert bubble with in_wa=9 -> stage0 becomes all-zero and the old stage0 record moves to stage1. Assert bubble+hold -> no change.
- Flush priority: assert flush+hold with a full chain -> all taps 0 after one edge.
- Zero-suppress: in_wa=0, in_we=1, in_valid=1 -> tap_we[0]=0 with PIPE_STAGE_ZERO_SUPPRESS_EN defined; tap_we[0]=1 without it.

Source files
------------

// File: rtl/pipe_stage_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : pipe_stage_chain                                           |
// | Description : Configurable chain of DEPTH pipeline registers carrying an |
// |               opaque payload plus the hazard fields (valid, GRF write    |
// |               enable, write address, Tnew). Tnew saturating-decrements   |
// |               on every advance. Supports global hold, bubble injection   |
// |               into stage 0, and full flush.                              |
// | Ports       : clk, reset (sync, active-low)                              |
// |               hold / bubble / flush        - chain control               |
// |               in_valid/we/wa/tnew/data      - record entering stage 0    |
// |               out_*                         - record in stage DEPTH-1    |
// |               tap_valid/we/wa/tnew          - every stage, packed by k   |
// | Option      : define PIPE_STAGE_ZERO_SUPPRESS_EN to clear the captured   |
// |               write enable when in_wa == 0 or in_valid == 0.             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module pipe_stage_chain #(
  parameter int DATA_W = 96,
  parameter int DEPTH  = 2,
  parameter int TNEW_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     hold,
  input  logic                     bubble,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_we,
  input  logic [4:0]               in_wa,
  input  logic [TNEW_W-1:0]        in_tnew,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     out_valid,
  output logic                     out_we,
  output logic [4:0]               out_wa,
  output logic [TNEW_W-1:0]        out_tnew,
  output logic [DATA_W-1:0]        out_data,
  output logic [DEPTH-1:0]         tap_valid,
  output logic [DEPTH-1:0]         tap_we,
  output logic [5*DEPTH-1:0]       tap_wa,
  output logic [TNEW_W*DEPTH-1:0]  tap_tnew
);

  // Saturating decrement: Tnew never wraps below zero.
  function automatic logic [TNEW_W-1:0] dec(input logic [TNEW_W-1:0] x);
    return (x == '0) ? '0 : x - TNEW_W'(1);
  endfunction

  logic [DEPTH-1:0]  valid_q, valid_d;
  logic [DEPTH-1:0]  we_q,    we_d;
  logic [4:0]        wa_q    [DEPTH];
  logic [4:0]        wa_d    [DEPTH];
  logic [TNEW_W-1:0] tnew_q  [DEPTH];
  logic [TNEW_W-1:0] tnew_d  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [DATA_W-1:0] data_d  [DEPTH];

  logic in_we_eff;

`ifdef PIPE_STAGE_ZERO_SUPPRESS_EN
  // Writes to $0 and writes from invalid slots are dropped at the entry.
  assign in_we_eff = in_we & in_valid & (in_wa != 5'd0);
`else
  assign in_we_eff = in_we;
`endif

  // Next-state: flush > hold > bubble > normal advance (reset handled in the flop).
  always_comb begin
    valid_d = valid_q;
    we_d    = we_q;
    wa_d    = wa_q;
    tnew_d  = tnew_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = '0;
      we_d    = '0;
      for (int k = 0; k < DEPTH; k++) begin
        wa_d[k]   = '0;
        tnew_d[k] = '0;
        data_d[k] = '0;
      end
    end else if (!hold) begin
      if (bubble) begin
        valid_d[0] = 1'b0;
        we_d[0]    = 1'b0;
        wa_d[0]    = '0;
        tnew_d[0]  = '0;
        data_d[0]  = '0;
      end else begin
        valid_d[0] = in_valid;
        we_d[0]    = in_we_eff;
        wa_d[0]    = in_wa;
        tnew_d[0]  = dec(in_tnew);
        data_d[0]  = in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        valid_d[k] = valid_q[k-1];
        we_d[k]    = we_q[k-1];
        wa_d[k]    = wa_q[k-1];
        tnew_d[k]  = dec(tnew_q[k-1]);
        data_d[k]  = data_q[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= '0;
      we_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        wa_q[k]   <= '0;
        tnew_q[k] <= '0;
        data_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      we_q    <= we_d;
      wa_q    <= wa_d;
      tnew_q  <= tnew_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_we    = we_q[DEPTH-1];
  assign out_wa    = wa_q[DEPTH-1];
  assign out_tnew  = tnew_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  assign tap_valid = valid_q;
  assign tap_we    = we_q;

  generate
    for (genvar g = 0; g < DEPTH; g++) begin : g_tap
      assign tap_wa[5*g +: 5]            = wa_q[g];
      assign tap_tnew[TNEW_W*g +: TNEW_W] = tnew_q[g];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_chain.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_pipe_stage_chain                                        |
// | Description : Self-checking bench for pipe_stage_chain (DEPTH=3,         |
// |               TNEW_W=2, DATA_W=32) with a record-level reference model   |
// |               and directed scenarios: reset, Tnew countdown, hold,       |
// |               bubble vs hold, flush priority, $0 write suppression.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_pipe_stage_chain;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 3;
  localparam int TNEW_W = 2;

  logic                     clk = 1'b0;
  logic                     reset, hold, bubble, flush;
  logic                     in_valid, in_we;
  logic [4:0]               in_wa;
  logic [TNEW_W-1:0]        in_tnew;
  logic [DATA_W-1:0]        in_data;
  logic                     out_valid, out_we;
  logic [4:0]               out_wa;
  logic [TNEW_W-1:0]        out_tnew;
  logic [DATA_W-1:0]        out_data;
  logic [DEPTH-1:0]         tap_valid, tap_we;
  logic [5*DEPTH-1:0]       tap_wa;
  logic [TNEW_W*DEPTH-1:0]  tap_tnew;

  pipe_stage_chain #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TNEW_W(TNEW_W)) dut (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
    .in_valid(in_valid), .in_we(in_we), .in_wa(in_wa), .in_tnew(in_tnew),
    .in_data(in_data),
    .out_valid(out_valid), .out_we(out_we), .out_wa(out_wa),
    .out_tnew(out_tnew), .out_data(out_data),
    .tap_valid(tap_valid), .tap_we(tap_we), .tap_wa(tap_wa), .tap_tnew(tap_tnew)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

`ifdef PIPE_STAGE_ZERO_SUPPRESS_EN
  localparam bit SUPPRESS = 1'b1;
`else
  localparam bit SUPPRESS = 1'b0;
`endif

  // Reference model: one record per stage, Tnew kept as a plain integer.
  typedef struct {
    bit         v;
    bit         we;
    bit [4:0]   wa;
    int         tnew;
    bit [31:0]  data;
  } rec_t;

  rec_t m [DEPTH];

  function automatic rec_t zero_rec();
    rec_t r;
    r.v = 0; r.we = 0; r.wa = 0; r.tnew = 0; r.data = 0;
    return r;
  endfunction

  function automatic int sat_dec(input int x);
    return (x > 0) ? x - 1 : 0;
  endfunction

  // Apply one clock edge to the model using the currently driven inputs.
  task automatic model_step();
    rec_t nr;
    if (!reset || flush) begin
      for (int k = 0; k < DEPTH; k++) m[k] = zero_rec();
    end else if (!hold) begin
      for (int k = DEPTH - 1; k >= 1; k--) begin
        m[k]      = m[k-1];
        m[k].tnew = sat_dec(m[k-1].tnew);
      end
      if (bubble) begin
        nr = zero_rec();
      end else begin
        nr.v    = in_valid;
        nr.we   = in_we;
        if (SUPPRESS && (in_wa == 5'd0 || !in_valid)) nr.we = 1'b0;
        nr.wa   = in_wa;
        nr.tnew = sat_dec(int'(in_tnew));
        nr.data = in_data;
      end
      m[0] = nr;
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [DEPTH-1:0]        ev, ew;
      logic [5*DEPTH-1:0]      ea;
      logic [TNEW_W*DEPTH-1:0] et;
      for (int k = 0; k < DEPTH; k++) begin
        ev[k]              = m[k].v;
        ew[k]              = m[k].we;
        ea[5*k +: 5]       = m[k].wa;
        et[TNEW_W*k +: TNEW_W] = TNEW_W'(m[k].tnew);
      end
      chk("out_valid", 64'(out_valid), 64'(m[DEPTH-1].v));
      chk("out_we",    64'(out_we),    64'(m[DEPTH-1].we));
      chk("out_wa",    64'(out_wa),    64'(m[DEPTH-1].wa));
      chk("out_tnew",  64'(out_tnew),  64'(m[DEPTH-1].tnew));
      chk("out_data",  64'(out_data),  64'(m[DEPTH-1].data));
      chk("tap_valid", 64'(tap_valid), 64'(ev));
      chk("tap_we",    64'(tap_we),    64'(ew));
      chk("tap_wa",    64'(tap_wa),    64'(ea));
      chk("tap_tnew",  64'(tap_tnew),  64'(et));
    end
  end

  task automatic cyc(input bit r, input bit h, input bit b, input bit f,
                     input bit v, input bit w, input bit [4:0] a,
                     input int tn, input bit [31:0] d);
    reset = r; hold = h; bubble = b; flush = f;
    in_valid = v; in_we = w; in_wa = a; in_tnew = TNEW_W'(tn); in_data = d;
    @(posedge clk);
    #1;
    model_step();
    chk_en = 1'b1;
    @(negedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) m[k] = zero_rec();
    reset = 0; hold = 0; bubble = 0; flush = 0;
    in_valid = 0; in_we = 0; in_wa = 0; in_tnew = 0; in_data = 0;

    // Reset held low while a valid instruction is driven.
    cyc(0,0,0,0, 1,1,5'd1,3,32'hAAAA);
    cyc(0,0,0,0, 1,1,5'd1,3,32'hAAAA);
    chk("lit_rst_out_data",  64'(out_data),  64'h0);
    chk("lit_rst_tap_valid", 64'(tap_valid), 64'h0);
    chk("lit_rst_tap_wa",    64'(tap_wa),    64'h0);

    // Release: payload reaches out after DEPTH edges; Tnew 3 -> 2 -> 1 -> 0.
    cyc(1,0,0,0, 1,1,5'd1,3,32'hAAAA);
    cyc(1,0,0,0, 1,1,5'd1,3,32'hAAAA);
    cyc(1,0,0,0, 1,1,5'd1,3,32'hAAAA);
    chk("lit_rel_out_data", 64'(out_data), 64'hAAAA);
    chk("lit_rel_out_tnew", 64'(out_tnew), 64'h0);

    // Tnew countdown.
    cyc(1,0,0,0, 1,1,5'd2,2,32'h0002);
    chk("lit_tnew_s0", 64'(tap_tnew[1:0]), 64'd1);
    cyc(1,0,0,0, 1,1,5'd4,0,32'h0004);
    chk("lit_tnew_s0_zero", 64'(tap_tnew[1:0]), 64'd0);
    chk("lit_tnew_s1",      64'(tap_tnew[3:2]), 64'd0);
    cyc(1,0,0,0, 1,1,5'd4,0,32'h0005);
    chk("lit_tnew_all_zero", 64'(tap_tnew), 64'd0);

    // Hold: stage0 wa=5 tnew=1, stage1 wa=7 tnew=1.
    cyc(1,0,0,0, 1,1,5'd7,3,32'h0007);
    cyc(1,0,0,0, 1,1,5'd5,2,32'h0005);
    for (int i = 0; i < 3; i++) begin
      cyc(1,1,0,0, 1,1,5'(11 + i),3,32'h1100 + 32'(i));
      chk("lit_hold_wa",   64'(tap_wa[9:0]),   64'({5'd7, 5'd5}));
      chk("lit_hold_tnew", 64'(tap_tnew[3:0]), 64'b0101);
    end
    cyc(1,0,0,0, 1,1,5'd3,1,32'h0003);
    chk("lit_resume_wa",   64'(tap_wa),   64'({5'd7, 5'd5, 5'd3}));
    chk("lit_resume_tnew", 64'(tap_tnew), 64'd0);

    // Bubble, then bubble+hold.
    cyc(1,0,1,0, 1,1,5'd9,3,32'h0009);
    chk("lit_bub_s0_wa", 64'(tap_wa[4:0]), 64'd0);
    chk("lit_bub_s1_wa", 64'(tap_wa[9:5]), 64'd3);
    chk("lit_bub_s0_v",  64'(tap_valid[0]), 64'd0);
    cyc(1,1,1,0, 1,1,5'd9,3,32'h0009);
    chk("lit_bubhold_wa", 64'(tap_wa), 64'({5'd5, 5'd3, 5'd0}));

    // Flush beats hold on a full chain.
    cyc(1,0,0,0, 1,1,5'd1,3,32'h0101);
    cyc(1,0,0,0, 1,1,5'd2,3,32'h0202);
    cyc(1,0,0,0, 1,1,5'd3,3,32'h0303);
    cyc(1,1,0,1, 1,1,5'd4,3,32'h0404);
    chk("lit_flush_valid", 64'(tap_valid), 64'd0);
    chk("lit_flush_wa",    64'(tap_wa),    64'd0);
    chk("lit_flush_data",  64'(out_data),  64'd0);

    // Write-enable capture for $0 and for an invalid slot.
    cyc(1,0,0,0, 1,1,5'd0,1,32'h0A0A);
    chk("lit_we_wa0", 64'(tap_we[0]), 64'(!SUPPRESS));
    cyc(1,0,0,0, 0,1,5'd6,1,32'h0B0B);
    chk("lit_we_invalid", 64'(tap_we[0]), 64'(!SUPPRESS));
    chk("lit_we_wa0_s1",  64'(tap_we[1]), 64'(!SUPPRESS));

    // Reset low mid-stream overrides hold, bubble and flush.
    cyc(1,0,0,0, 1,1,5'd8,2,32'h0808);
    cyc(0,1,1,1, 1,1,5'd8,2,32'h0909);
    chk("lit_midrst_valid", 64'(tap_valid), 64'd0);
    chk("lit_midrst_data",  64'(out_data),  64'd0);
    cyc(1,0,0,0, 1,0,5'd12,1,32'h0C0C);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
